mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-ported, byte-addressed, little-endian 32-bit data memory between
//  instruction fetch (port I, read-only) and load/store (port D, read/write).
//  Sits between the CPU front/back ends and the memory; registers all memory controls
//  so the memory sees stable address/data before and during every write level.
// PARAMETERS
//  ADDR_W  15  byte-address width (memory depth 2**ADDR_W bytes)
//  FAIR    1   1: round-robin between I and D; 0: fixed priority, D always wins
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  iReq       in   1       fetch request; held high until iAck
//  iAddr      in   ADDR_W  fetch byte address
//  iData      out  32      fetched word, valid while iAck=1
//  iAck       out  1       one-cycle completion pulse
//  dReq       in   1       load/store request; held high until dAck
//  dWrite     in   1       1=store, 0=load
//  dSize      in   2       00 byte, 01 half, 10 word (used only with SUBWORD_EN)
//  dAddr      in   ADDR_W  byte address
//  dWData     in   32      store data, right-justified
//  dRData     out  32      load data, valid while dAck=1
//  dAck       out  1       one-cycle completion pulse
//  dErr       out  1       misaligned access flag, valid with dAck
//  memAddr    out  ADDR_W  memory byte address (registered)
//  memWData   out  32      memory write data (registered)
//  memRead    out  1       memory read enable
//  memWrite   out  1       memory write level
//  memRData   in   32      memory read data (combinational from memAddr)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, last-grant pointer = I (so D wins first tie).
//  States: IDLE -> ACCESS -> DONE -> IDLE; SUBWORD_EN adds RMW_RD -> RMW_WR for sub-word stores.
//  IDLE: sample iReq/dReq; grant one; latch addr/wdata/size/dir; memAddr loaded on that edge.
//   Both pending: FAIR=1 grants port not granted last; FAIR=0 grants D.
//   None pending: stay IDLE, memRead=memWrite=0.
//  ACCESS (1 cycle): memAddr/memWData stable from cycle start; memRead=1 for loads/fetch,
//   memWrite=1 for word store; memRData captured into iData/dRData at cycle end.
//  DONE (1 cycle): ack of granted port =1, memRead=memWrite=0; pointer updated; -> IDLE.
//  Latency: req sampled edge N -> ack high in cycle N+2; max throughput 1 access / 3 cycles.
//  Requester drops req in the ack cycle; a req still high in DONE is not re-sampled until IDLE.
//  memAddr/memWData change only on the IDLE->grant edge; never while memWrite=1.
//  Alignment: word needs addr[1:0]=0, half needs addr[0]=0; misaligned D access skips
//   ACCESS (no memRead/memWrite), goes IDLE->DONE with dAck=1, dErr=1, dRData=0.
//   iAddr[1:0]!=0: fetch forced to aligned word (low bits ignored), no error.
//  Address wrap: addr+3 beyond 2**ADDR_W-1 is the memory's concern; arbiter passes memAddr as-is.
//  Async reset mid-operation: FSM to IDLE, memWrite/memRead/acks drop immediately; the
//   interrupted word's contents are undefined; requesters must reissue.
// CONFIGURATION
//  SUBWORD_EN defined: dSize honoured. Loads return selected byte/half right-justified,
//   zero-extended. Byte/half store: ACCESS reads word (RMW_RD captures memRData),
//   RMW_WR merges lanes at addr[1:0] and asserts memWrite=1 one cycle with merged
//   memWData set up on the preceding edge, then DONE; latency 4 cycles. Port I blocked meanwhile.
//  SUBWORD_EN undefined: dSize ignored, every D access is a word; no RMW states.
// TESTING
//  1 Reset: rst_n=0 mid-write (memWrite=1) -> memWrite, acks, dErr drop same cycle, FSM IDLE.
//  2 Word store dAddr=0x0010 dWData=0xDEADBEEF, then load 0x0010 -> dAck at +2, dRData=0xDEADBEEF.
//  3 iReq and dReq same edge, FAIR=1, repeated -> grants alternate D,I,D,I; FAIR=0 -> D only.
//  4 Fetch iAddr=0x0006 after word at 0x0004 = 0x12345678 -> iData=0x12345678, no error.
//  5 Word load dAddr=0x0011 -> dAck, dErr=1, dRData=0, memRead never asserted.
//  6 SUBWORD_EN: word 0x11223344 at 0x0020, sb 0xAA to 0x0021 -> word 0x1122AA44, dAck at +4;
//    lh at 0x0022 -> dRData=0x00001122.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported, byte-addressed, little-endian 32-bit memory between
//   instruction fetch (port I, read-only) and load/store (port D, read/write).
//   Every memory control is driven from flops, so address and data are stable
//   before and during each write level.
//
//   Flow: IDLE -> ACCESS -> DONE -> IDLE (3 cycles per access). A misaligned D
//   access goes IDLE -> DONE with dErr set and no memory cycle. A sub-word store
//   goes ACCESS (read) -> RMW_RD (merge) -> RMW_WR (write) -> DONE.
//
//   Optional feature macro: SUBWORD_EN
//     defined   : dSize honoured. Loads are zero-extended. Byte/half stores use read-modify-write.
//     undefined : every D access is a 32-bit word and dSize is ignored.
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   iReq/iAddr -> iData/iAck          fetch port (word-aligned, low bits ignored)
//   dReq/dWrite/dSize/dAddr/dWData    load/store request
//   dRData/dAck/dErr                  load data, completion pulse, misalign flag
//   memAddr/memWData/memRead/memWrite memory controls (registered)
//   memRData                          memory read data (combinational from memAddr)
module mem_port_arbiter #(
    parameter int ADDR_W = 15,
    parameter int FAIR   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iReq,
    input  logic [ADDR_W-1:0] iAddr,
    output logic [31:0]       iData,
    output logic              iAck,
    input  logic              dReq,
    input  logic              dWrite,
    input  logic [1:0]        dSize,
    input  logic [ADDR_W-1:0] dAddr,
    input  logic [31:0]       dWData,
    output logic [31:0]       dRData,
    output logic              dAck,
    output logic              dErr,
    output logic [ADDR_W-1:0] memAddr,
    output logic [31:0]       memWData,
    output logic              memRead,
    output logic              memWrite,
    input  logic [31:0]       memRData
);

    typedef enum logic [2:0] {IDLE, ACCESS, RMW_RD, RMW_WR, DONE} state_t;

    state_t state, state_n;
    logic   last_d;      // 1: D held the most recent grant
    logic   gnt_d;       // granted port of the current access (1 = D)
    logic   is_wr;
    logic   err;
    logic   pick_d, pick_i, d_mis, sub_st;
    logic [31:0] load_data;

    // Fetch low address bits are intentionally dropped.
    logic unused_bits;

    // Tie-break: with FAIR the port that did not win last time goes first; after
    // reset last_d=0, so D wins the first tie.
    assign pick_d = dReq && (!iReq || (FAIR == 0) || !last_d);
    assign pick_i = iReq && !pick_d;

`ifdef SUBWORD_EN
    logic [1:0]  size_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic [31:0] rmw_q;
    logic [31:0] lane_sh;
    logic [31:0] lane_mask;
    logic [31:0] merged;

    assign unused_bits = ^iAddr[1:0];
    // Byte accesses never misalign; half needs bit 0 clear; word (10/11) both bits.
    assign d_mis  = (dSize == 2'b00) ? 1'b0 :
                    (dSize == 2'b01) ? dAddr[0] : |dAddr[1:0];
    assign sub_st = gnt_d && is_wr && !size_q[1];

    assign lane_sh   = memRData >> {off_q, 3'b000};
    assign load_data = (size_q == 2'b00) ? {24'h0, lane_sh[7:0]}  :
                       (size_q == 2'b01) ? {16'h0, lane_sh[15:0]} : memRData;

    assign lane_mask = ((size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << {off_q, 3'b000};
    assign merged    = (rmw_q & ~lane_mask) | ((wdata_q << {off_q, 3'b000}) & lane_mask);
`else
    assign unused_bits = ^{iAddr[1:0], dSize};
    assign d_mis       = |dAddr[1:0];
    assign sub_st      = 1'b0;
    assign load_data   = memRData;
`endif

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // ---------------- next state ----------------
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (pick_d)      state_n = d_mis ? DONE : ACCESS;
                else if (pick_i) state_n = ACCESS;
            end
            ACCESS:  state_n = sub_st ? RMW_RD : DONE;
`ifdef SUBWORD_EN
            RMW_RD:  state_n = RMW_WR;
            RMW_WR:  state_n = DONE;
`endif
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    // Decoded from the state flop only, so async reset drops them at once.
    always_comb begin
        memRead  = 1'b0;
        memWrite = 1'b0;
        iAck     = 1'b0;
        dAck     = 1'b0;
        dErr     = 1'b0;
        case (state)
            ACCESS: begin
                // A sub-word store reads the whole word here first.
                memRead  = !gnt_d || !is_wr || sub_st;
                memWrite = gnt_d && is_wr && !sub_st;
            end
`ifdef SUBWORD_EN
            RMW_WR: memWrite = 1'b1;
`endif
            DONE: begin
                iAck = !gnt_d;
                dAck = gnt_d;
                dErr = gnt_d && err;
            end
            default: ;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_d   <= 1'b0;
            gnt_d    <= 1'b0;
            is_wr    <= 1'b0;
            err      <= 1'b0;
            memAddr  <= '0;
            memWData <= '0;
            iData    <= '0;
            dRData   <= '0;
`ifdef SUBWORD_EN
            size_q   <= '0;
            off_q    <= '0;
            wdata_q  <= '0;
            rmw_q    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pick_d) begin
                        gnt_d    <= 1'b1;
                        is_wr    <= dWrite;
                        err      <= d_mis;
                        memWData <= dWData;
                        if (d_mis) dRData <= '0;
`ifdef SUBWORD_EN
                        memAddr  <= {dAddr[ADDR_W-1:2], 2'b00};
                        size_q   <= dSize;
                        off_q    <= dAddr[1:0];
                        wdata_q  <= dWData;
`else
                        memAddr  <= dAddr;
`endif
                    end else if (pick_i) begin
                        gnt_d    <= 1'b0;
                        is_wr    <= 1'b0;
                        err      <= 1'b0;
                        memAddr  <= {iAddr[ADDR_W-1:2], 2'b00};
                    end
                end
                ACCESS: begin
                    if (!gnt_d)      iData  <= memRData;
                    else if (!is_wr) dRData <= load_data;
`ifdef SUBWORD_EN
                    if (sub_st) rmw_q <= memRData;
`endif
                end
`ifdef SUBWORD_EN
                // Merged word is set up one edge ahead of the write level.
                RMW_RD: memWData <= merged;
`endif
                DONE: last_d <= gnt_d;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    localparam int AW = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          iReq, dReq, dWrite;
    logic [AW-1:0] iAddr, dAddr;
    logic [1:0]    dSize;
    logic [31:0]   dWData;
    logic [31:0]   iData, dRData, memWData, memRData;
    logic          iAck, dAck, dErr, memRead, memWrite;
    logic [AW-1:0] memAddr;

    // second instance, fixed priority, own request lines
    logic          d0_iReq, d0_dReq;
    logic [31:0]   d0_iData, d0_dRData, d0_memWData;
    logic          d0_iAck, d0_dAck, d0_dErr, d0_memRead, d0_memWrite;
    logic [AW-1:0] d0_memAddr;

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit          port;   // 1 = D, 0 = I
        logic [31:0] rdata;
        bit          err;
        int          lat;
    } exp_t;
    exp_t sb[$];

    logic [7:0] mem [0:(1<<AW)-1];

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .FAIR(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .iReq(iReq), .iAddr(iAddr), .iData(iData), .iAck(iAck),
        .dReq(dReq), .dWrite(dWrite), .dSize(dSize), .dAddr(dAddr), .dWData(dWData),
        .dRData(dRData), .dAck(dAck), .dErr(dErr),
        .memAddr(memAddr), .memWData(memWData), .memRead(memRead), .memWrite(memWrite),
        .memRData(memRData)
    );

    mem_port_arbiter #(.ADDR_W(AW), .FAIR(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .iReq(d0_iReq), .iAddr(iAddr), .iData(d0_iData), .iAck(d0_iAck),
        .dReq(d0_dReq), .dWrite(dWrite), .dSize(dSize), .dAddr(dAddr), .dWData(dWData),
        .dRData(d0_dRData), .dAck(d0_dAck), .dErr(d0_dErr),
        .memAddr(d0_memAddr), .memWData(d0_memWData), .memRead(d0_memRead), .memWrite(d0_memWrite),
        .memRData(32'h0)
    );

    // little-endian byte memory, wraps at the top of the address space
    always_comb memRData = {mem[memAddr + AW'(3)], mem[memAddr + AW'(2)],
                            mem[memAddr + AW'(1)], mem[memAddr]};

    always @(posedge clk) begin
        if (memWrite) begin
            mem[memAddr]          <= memWData[7:0];
            mem[memAddr + AW'(1)] <= memWData[15:8];
            mem[memAddr + AW'(2)] <= memWData[23:16];
            mem[memAddr + AW'(3)] <= memWData[31:24];
        end
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // D transaction: expectation queued, request held until ack, then one idle cycle.
    task automatic t_d(string tag, logic wr, logic [1:0] sz, logic [AW-1:0] a,
                       logic [31:0] wd, logic [31:0] exp_rd, bit exp_err, int exp_lat);
        exp_t e;
        bit   got = 0;
        bit   rd_seen = 0;
        int   lat = 0;
        e.port = 1'b1; e.rdata = exp_rd; e.err = exp_err; e.lat = exp_lat;
        sb.push_back(e);
        dWrite = wr; dSize = sz; dAddr = a; dWData = wd; dReq = 1'b1;
        for (int c = 1; c <= 12 && !got; c++) begin
            tick();
            if (memRead || memWrite) rd_seen = 1;
            if (dAck) begin got = 1; lat = c; end
        end
        e = sb.pop_front();
        chk({tag, ".ack"}, 32'(got), 32'd1);
        if (got) begin
            chk({tag, ".lat"}, lat, e.lat);
            chk({tag, ".err"}, 32'(dErr), 32'(e.err));
            chk({tag, ".iack"}, 32'(iAck), 32'd0);
            if (!wr || e.err) chk({tag, ".rdata"}, dRData, e.rdata);
            if (e.err) chk({tag, ".nomem"}, 32'(rd_seen), 32'd0);
        end
        dReq = 1'b0;
        tick();
    endtask

    task automatic t_i(string tag, logic [AW-1:0] a, logic [31:0] exp_rd);
        exp_t e;
        bit   got = 0;
        int   lat = 0;
        e.port = 1'b0; e.rdata = exp_rd; e.err = 1'b0; e.lat = 2;
        sb.push_back(e);
        iAddr = a; iReq = 1'b1;
        for (int c = 1; c <= 12 && !got; c++) begin
            tick();
            if (iAck) begin got = 1; lat = c; end
        end
        e = sb.pop_front();
        chk({tag, ".ack"}, 32'(got), 32'd1);
        if (got) begin
            chk({tag, ".lat"}, lat, e.lat);
            chk({tag, ".data"}, iData, e.rdata);
            chk({tag, ".derr"}, 32'({dAck, dErr}), 32'd0);
        end
        iReq = 1'b0;
        tick();
    endtask

    // Both ports request continuously; each ack is matched to the next queued grant.
    task automatic run_arb(string tag, bit use0, int n);
        exp_t e;
        int   k = 0;
        bit   rearm = 0;
        bit   a_d, a_i;
        dWrite = 1'b0; dSize = 2'b10; dAddr = '0; iAddr = '0;
        if (use0) begin d0_iReq = 1'b1; d0_dReq = 1'b1; end
        else      begin iReq = 1'b1;    dReq = 1'b1;    end
        for (int c = 0; c < 16 * n && k < n; c++) begin
            tick();
            if (rearm) begin
                if (use0) begin d0_iReq = 1'b1; d0_dReq = 1'b1; end
                else      begin iReq = 1'b1;    dReq = 1'b1;    end
                rearm = 0;
            end
            a_d = use0 ? d0_dAck : dAck;
            a_i = use0 ? d0_iAck : iAck;
            if (a_d || a_i) begin
                e = sb.pop_front();
                chk($sformatf("%s.grant%0d", tag, k), 32'(a_d), 32'(e.port));
                k++;
                if (use0) begin if (a_d) d0_dReq = 1'b0; else d0_iReq = 1'b0; end
                else      begin if (a_d) dReq = 1'b0;    else iReq = 1'b0;    end
                rearm = 1;
            end
        end
        chk({tag, ".count"}, k, n);
        sb.delete();
        iReq = 1'b0; dReq = 1'b0; d0_iReq = 1'b0; d0_dReq = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        exp_t e;
        bit   seen;
        rst_n = 1'b0;
        iReq = 1'b0; dReq = 1'b0; dWrite = 1'b0; dSize = 2'b10;
        iAddr = '0; dAddr = '0; dWData = '0;
        d0_iReq = 1'b0; d0_dReq = 1'b0;
        repeat (3) tick();

        // reset state
        chk("rst.ctrl", 32'({memRead, memWrite, iAck, dAck, dErr}), 32'd0);
        chk("rst.addr", 32'(memAddr), 32'd0);
        chk("rst.wdata", memWData, 32'd0);
        chk("rst.rdata", iData | dRData, 32'd0);
        rst_n = 1'b1;
        tick();

        // reset in the middle of a write level
        dWrite = 1'b1; dSize = 2'b10; dAddr = 15'h0040; dWData = 32'h0000_0055; dReq = 1'b1;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            tick();
            if (memWrite) seen = 1;
        end
        chk("midrst.wr_seen", 32'(seen), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst.drop", 32'({memWrite, memRead, dAck, iAck, dErr}), 32'd0);
        chk("midrst.addr", 32'(memAddr), 32'd0);
        dReq = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("midrst.idle", 32'({memWrite, memRead, dAck, iAck}), 32'd0);

        // arbitration: FAIR=1 alternates starting with D, FAIR=0 always D
        e.rdata = '0; e.err = 0; e.lat = 0;
        e.port = 1; sb.push_back(e);
        e.port = 0; sb.push_back(e);
        e.port = 1; sb.push_back(e);
        e.port = 0; sb.push_back(e);
        run_arb("fair1", 1'b0, 4);
        e.port = 1; sb.push_back(e); sb.push_back(e); sb.push_back(e);
        run_arb("fair0", 1'b1, 3);

        // word store / load
        t_d("sw10", 1'b1, 2'b10, 15'h0010, 32'hDEAD_BEEF, 32'h0, 1'b0, 2);
        t_d("lw10", 1'b0, 2'b10, 15'h0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 2);

        // fetch with misaligned address is forced to the word
        t_d("sw04", 1'b1, 2'b10, 15'h0004, 32'h1234_5678, 32'h0, 1'b0, 2);
        t_i("if06", 15'h0006, 32'h1234_5678);
        t_i("if10", 15'h0013, 32'hDEAD_BEEF);

        // misaligned D accesses: error, no memory cycle, store has no effect
        t_d("lw11", 1'b0, 2'b10, 15'h0011, 32'h0, 32'h0, 1'b1, 1);
        t_d("sw12", 1'b1, 2'b10, 15'h0012, 32'hFFFF_FFFF, 32'h0, 1'b1, 1);
        t_d("lw10b", 1'b0, 2'b10, 15'h0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 2);

        // top-of-memory word
        t_d("swtop", 1'b1, 2'b10, 15'h7FFC, 32'hCAFE_F00D, 32'h0, 1'b0, 2);
        t_d("lwtop", 1'b0, 2'b10, 15'h7FFC, 32'h0, 32'hCAFE_F00D, 1'b0, 2);

`ifdef SUBWORD_EN
        t_d("sw20", 1'b1, 2'b10, 15'h0020, 32'h1122_3344, 32'h0, 1'b0, 2);
        t_d("sb21", 1'b1, 2'b00, 15'h0021, 32'h0000_00AA, 32'h0, 1'b0, 4);
        t_d("lw20", 1'b0, 2'b10, 15'h0020, 32'h0, 32'h1122_AA44, 1'b0, 2);
        t_d("lh22", 1'b0, 2'b01, 15'h0022, 32'h0, 32'h0000_1122, 1'b0, 2);
        t_d("lb21", 1'b0, 2'b00, 15'h0021, 32'h0, 32'h0000_00AA, 1'b0, 2);
        t_d("sh22", 1'b1, 2'b01, 15'h0022, 32'h0000_BEEF, 32'h0, 1'b0, 4);
        t_d("lw20b", 1'b0, 2'b10, 15'h0020, 32'h0, 32'hBEEF_AA44, 1'b0, 2);
        t_d("lh23", 1'b0, 2'b01, 15'h0023, 32'h0, 32'h0, 1'b1, 1);
`else
        // dSize ignored: a "byte" load still returns the full word
        t_d("lbw10", 1'b0, 2'b00, 15'h0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
